regfile_wr_arb: RTL
===================

REGFILE_WR_ARB -- requirements
Module: regfile_wr_arb

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 8: consecutive cycles a pending B entry may lose arbitration before stall_req asserts.
REQ-002 SHALL have parameter CLEAR_ON_RESET, default 1: 1 = zero-sweep all 256 registers after reset; 0 = skip the sweep.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 SHALL have port clock, input, 1: global clock; all state updates on posedge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port a_valid, input, 1: pipeline write-back request; no backpressure.
REQ-007 SHALL have port a_addr, input, 8: A write address.
REQ-008 SHALL have port a_data, input, 32: A write data.
REQ-009 SHALL have port b_valid, input, 1: load-return/debug write request.
REQ-010 SHALL have port b_ready, output, 1: B accepted when b_valid && b_ready at posedge.
REQ-011 SHALL have port b_addr, input, 8: B write address.
REQ-012 SHALL have port b_data, input, 32: B write data.
REQ-013 SHALL have port wr_en, output, 1: regfile write enable (regfile_in.wren).
REQ-014 SHALL have port wr_addr, output, 8: regfile write address (regfile_in.waddr).
REQ-015 SHALL have port wr_data, output, 32: regfile write data (regfile_in.wdata).
REQ-016 SHALL have port init_done, output, 1: clear sweep complete; port usable.
REQ-017 SHALL have port stall_req, output, 1: request to pipeline to drop a_valid so B can drain.
REQ-018 SHALL have port err_drop, output, 1: sticky; an A write was dropped.

Function
REQ-019 SHALL register wr_en/wr_addr/wr_data: a request granted in cycle N appears on the write port in cycle N+1.
REQ-020 SHALL implement states CLEAR and RUN; after reset, state is CLEAR when CLEAR_ON_RESET=1, else RUN.
REQ-021 In CLEAR, SHALL issue wr_en=1, wr_data=0, wr_addr=0..255 on consecutive cycles (256 writes), then enter RUN.
REQ-022 SHALL assert init_done from the first cycle in RUN onward.
REQ-023 In CLEAR, SHALL drop any a_valid and set err_drop; err_drop stays set until reset.
REQ-024 In CLEAR, SHALL hold b_ready=0.
REQ-025 SHALL buffer B requests in a 2-entry FIFO; b_ready=1 iff RUN and FIFO not full (registered view).
REQ-026 In RUN, SHALL always grant a_valid first; the FIFO head is written only in cycles with a_valid=0.
REQ-027 A B accept and a FIFO pop in the same cycle SHALL keep occupancy unchanged.
REQ-028 A B entry accepted in cycle N SHALL not be written before cycle N+2 (FIFO then output register).
REQ-029 SHALL keep a saturating starve counter: increment each cycle the FIFO is non-empty and A wins; clear on any FIFO pop or when the FIFO is empty.
REQ-030 SHALL assert stall_req the cycle after the counter reaches STARVE_LIMIT, holding it until the next FIFO pop.
REQ-031 SHALL write FIFO entries in acceptance order; same-address A/B writes land in grant order (the last grant wins).
REQ-032 SHALL drive wr_en=0 in RUN when neither A nor the FIFO has a request.

Reset
REQ-033 On rst_n=0, SHALL immediately drive wr_en=0, wr_addr=0, wr_data=0, b_ready=0, init_done=0, stall_req=0, err_drop=0.
REQ-034 On rst_n=0, SHALL empty the FIFO, clear the starve counter, and reset the clear address to 0.
REQ-035 Reset asserted mid-sweep SHALL restart the sweep at address 0 after release.
REQ-036 Reset asserted with FIFO entries pending SHALL discard them without writing.

Verification
REQ-037 Clear sweep: release reset with CLEAR_ON_RESET=1 -> 256 writes with data 0 at addr 0..255 on cycles 1..256; init_done=1 on cycle 257.
REQ-038 A priority: in RUN, drive a_valid with a_addr=5 and b_valid with b_addr=6 in the same cycle -> addr 5 written at N+1, addr 6 written at N+2.
REQ-039 FIFO full: hold a_valid=1 and offer 3 B writes -> b_ready drops after 2 accepts; after a_valid=0, both entries are written in order.
REQ-040 Starvation: hold a_valid=1 with 1 B entry pending -> stall_req=1 after 8 losses; a_valid=0 -> B written, stall_req=0 the next cycle.
REQ-041 Drop: a_valid=1 during CLEAR -> no A write appears; err_drop=1 and stays set through RUN.
REQ-042 Reset mid-sweep: assert rst_n=0 at clear address 100, then release -> sweep restarts at 0; init_done stays 0 until 256 more writes complete.

Source files
------------

// File: rtl/regfile_wr_arb.sv
// regfile_wr_arb
// Write-port arbiter in front of a single-write-port register file.
// After reset it can zero-sweep all 256 registers (CLEAR). It then
// arbitrates between the pipeline write-back port (A) and the
// load-return/debug port (B) (RUN).
//
// A has strict priority and no backpressure. B requests go through a
// 2-entry FIFO and drain only in cycles where A is idle. A saturating
// starve counter raises stall_req so the pipeline can let B drain.
//
// Ports
//   clock      : global clock, all state updates on posedge
//   rst_n      : asynchronous active-low reset
//   a_valid    : A write request (no backpressure)
//   a_addr     : A write address
//   a_data     : A write data
//   b_valid    : B write request
//   b_ready    : B accepted when b_valid && b_ready at posedge
//   b_addr     : B write address
//   b_data     : B write data
//   wr_en      : registered regfile write enable
//   wr_addr    : registered regfile write address
//   wr_data    : registered regfile write data
//   init_done  : clear sweep complete, port usable
//   stall_req  : asks the pipeline to drop a_valid so B can drain
//   err_drop   : sticky, an A write arrived during CLEAR and was dropped
`timescale 1ns/1ps
module regfile_wr_arb #(
  parameter int unsigned STARVE_LIMIT   = 8,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        a_valid,
  input  logic [7:0]  a_addr,
  input  logic [31:0] a_data,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [7:0]  b_addr,
  input  logic [31:0] b_data,
  output logic        wr_en,
  output logic [7:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        init_done,
  output logic        stall_req,
  output logic        err_drop
);

  localparam int unsigned   SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  state_t        state;
  // Bit 8 marks that all 256 clear writes have been issued.
  logic [8:0]    clr_cnt;

  // FIFO entries are {addr, data}.
  logic [39:0]   fifo_mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count;
  logic [1:0]    count_nxt;
  logic [39:0]   head;

  logic [SW-1:0] starve;
  logic [SW-1:0] starve_nxt;
  logic          push;
  logic          pop;

  // The FIFO head only drains when A is idle. Push and pop in the same
  // cycle leave the occupancy unchanged. The starve counter counts
  // cycles in which a pending B entry loses to A.
  always_comb begin
    push       = (state == RUN) && b_valid && b_ready;
    pop        = (state == RUN) && !a_valid && (count != 2'd0);
    head       = fifo_mem[rd_ptr];
    count_nxt  = count + {1'b0, push} - {1'b0, pop};
    starve_nxt = starve;
    if (pop || (count == 2'd0)) begin
      starve_nxt = '0;
    end else if (a_valid && (starve != STARVE_MAX)) begin
      starve_nxt = starve + 1'b1;
    end
  end

  // FIFO storage holds only data, so it needs no reset. The count and
  // pointers decide which entries are valid.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {b_addr, b_data};
    end
  end

  // Main FSM. Every output is registered, so a grant in cycle N shows on
  // the write port in cycle N+1.
  //
  // CLEAR issues addresses 0..255. It then spends one more cycle in
  // CLEAR with wr_en low before entering RUN. In that same edge it raises
  // init_done and b_ready, so the port becomes usable on the cycle after
  // the last clear write.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state     <= CLEAR_ON_RESET ? CLEAR : RUN;
      clr_cnt   <= 9'd0;
      wr_en     <= 1'b0;
      wr_addr   <= 8'd0;
      wr_data   <= 32'd0;
      b_ready   <= 1'b0;
      init_done <= 1'b0;
      stall_req <= 1'b0;
      err_drop  <= 1'b0;
      count     <= 2'd0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      starve    <= '0;
    end else begin
      case (state)
        CLEAR: begin
          if (a_valid) begin
            err_drop <= 1'b1;
          end
          if (!clr_cnt[8]) begin
            wr_en   <= 1'b1;
            wr_addr <= clr_cnt[7:0];
            wr_data <= 32'd0;
            clr_cnt <= clr_cnt + 9'd1;
          end else begin
            wr_en     <= 1'b0;
            state     <= RUN;
            init_done <= 1'b1;
            b_ready   <= 1'b1;
          end
        end

        RUN: begin
          init_done <= 1'b1;
          if (a_valid) begin
            wr_en   <= 1'b1;
            wr_addr <= a_addr;
            wr_data <= a_data;
          end else if (count != 2'd0) begin
            wr_en   <= 1'b1;
            wr_addr <= head[39:32];
            wr_data <= head[31:0];
          end else begin
            wr_en <= 1'b0;
          end

          if (push) begin
            wr_ptr <= ~wr_ptr;
          end
          if (pop) begin
            rd_ptr <= ~rd_ptr;
          end
          count   <= count_nxt;
          b_ready <= (count_nxt != 2'd2);
          starve  <= starve_nxt;

          // stall_req rises with the counter hitting the limit and holds
          // until the starved entry finally drains.
          if (pop) begin
            stall_req <= 1'b0;
          end else if (starve_nxt == STARVE_MAX) begin
            stall_req <= 1'b1;
          end
        end

        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule
